// File: rtl/seven_seg_display_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_pkg                                                        |
// | Segment codes, controller states and helpers for the seven-segment   |
// | display controller.                                                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package seven_seg_pkg;

  // Active-low g..a patterns; bit 7 (DP) is handled separately.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         SEG_DP_BIT = 7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_STORE  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    case (nibble)
      4'd0:    seg_encode = SEG_0;
      4'd1:    seg_encode = SEG_1;
      4'd2:    seg_encode = SEG_2;
      4'd3:    seg_encode = SEG_3;
      4'd4:    seg_encode = SEG_4;
      4'd5:    seg_encode = SEG_5;
      4'd6:    seg_encode = SEG_6;
      4'd7:    seg_encode = SEG_7;
      4'd8:    seg_encode = SEG_8;
      4'd9:    seg_encode = SEG_9;
      default: seg_encode = SEG_BLANK;
    endcase
  endfunction

  // Decimal digits needed to hold any field_w-bit value: ceil(field_w*log10(2)).
  function automatic int bcd_digits(input int field_w, input int min_digits);
    int d;
    d = (field_w * 30103 + 99999) / 100000;
    return (d < min_digits) ? min_digits : d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seven_seg_display_ctrl_bcd_shift_add3.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | bcd_shift_add3                                                       |
// | Iterative double-dabble converter: one bit per step, full-width      |
// | accumulator, presents the low DIGITS digits and an overflow flag.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module bcd_shift_add3 #(
  parameter int FIELD_W = 7,
  parameter int DIGITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [FIELD_W-1:0]    i_value,
  output logic [4*DIGITS-1:0]   o_digits,
  output logic                  o_overflow
);
  import seven_seg_pkg::*;

  localparam int c_acc_digits = bcd_digits(FIELD_W, DIGITS);

  logic [FIELD_W-1:0]        r_shift;
  logic [4*c_acc_digits-1:0] r_acc;
  logic [4*c_acc_digits-1:0] w_adj;

  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < c_acc_digits; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift <= '0;
      r_acc   <= '0;
    end else if (i_load) begin
      r_shift <= i_value;
      r_acc   <= '0;
    end else if (i_step) begin
      {r_acc, r_shift} <= {w_adj, r_shift} << 1;
    end
  end

  assign o_digits = r_acc[4*DIGITS-1:0];

  // Any non-zero digit above the displayed ones means value >= 10^DIGITS.
  generate
    if (c_acc_digits > DIGITS) begin : g_ovf_upper
      assign o_overflow = |r_acc[4*c_acc_digits-1:4*DIGITS];
    end else begin : g_ovf_none
      assign o_overflow = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/seven_seg_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | seven_seg_display_ctrl                                               |
// | Captures binary fields, converts them to BCD one field at a time and |
// | commits all segment bytes atomically with DP, blanking and overflow. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module seven_seg_display_ctrl #(
  parameter int NUM_FIELDS       = 3,
  parameter int FIELD_W          = 7,
  parameter int DIGITS_PER_FIELD = 2
) (
  input  logic                                    clock,
  input  logic                                    reset,
  input  logic                                    update,
  input  logic [NUM_FIELDS*FIELD_W-1:0]           values,
  input  logic [NUM_FIELDS*DIGITS_PER_FIELD-1:0]  dp_mask,
  input  logic                                    blank_lz,
  output logic                                    busy,
  output logic                                    done,
  output logic [NUM_FIELDS*DIGITS_PER_FIELD*8-1:0] hex
);
  import seven_seg_pkg::*;

  localparam int c_digits = NUM_FIELDS * DIGITS_PER_FIELD;
  localparam int c_fidx_w = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
  localparam int c_cnt_w  = $clog2(FIELD_W);
  localparam logic [c_cnt_w-1:0]  c_last_step  = c_cnt_w'(FIELD_W - 1);
  localparam logic [c_fidx_w-1:0] c_last_field = c_fidx_w'(NUM_FIELDS - 1);

  state_t                          r_state;
  logic [NUM_FIELDS*FIELD_W-1:0]   r_values;
  logic [c_digits-1:0]             r_dp;
  logic                            r_blank_lz;
  logic [c_fidx_w-1:0]             r_field;
  logic [c_cnt_w-1:0]              r_cnt;
  logic [4*c_digits-1:0]           r_stage;
  logic [NUM_FIELDS-1:0]           r_stage_ovf;

  logic [4*DIGITS_PER_FIELD-1:0]   w_digits;
  logic                            w_ovf;
  logic [4*c_digits-1:0]           w_stage_m;
  logic [NUM_FIELDS-1:0]           w_ovf_m;
  logic [8*c_digits-1:0]           w_hex_next;
  logic                            w_lead;
  logic [3:0]                      w_nib;
  logic [7:0]                      w_byte;

  bcd_shift_add3 #(
    .FIELD_W (FIELD_W),
    .DIGITS  (DIGITS_PER_FIELD)
  ) u_bcd (
    .clk        (clock),
    .rst        (reset),
    .i_load     (r_state == ST_LOAD),
    .i_step     (r_state == ST_SHIFT),
    .i_value    (r_values[r_field*FIELD_W +: FIELD_W]),
    .o_digits   (w_digits),
    .o_overflow (w_ovf)
  );

  // Staging view with the field currently in STORE merged in, so the last
  // field can be committed in the same edge that stores it.
  always_comb begin
    w_stage_m = r_stage;
    w_ovf_m   = r_stage_ovf;
    w_stage_m[r_field*4*DIGITS_PER_FIELD +: 4*DIGITS_PER_FIELD] = w_digits;
    w_ovf_m[r_field] = w_ovf;
  end

  always_comb begin
    w_hex_next = '1;
    w_lead     = 1'b1;
    w_nib      = 4'd0;
    w_byte     = 8'hFF;
    for (int k = 0; k < NUM_FIELDS; k++) begin
      w_lead = 1'b1;
      for (int j = DIGITS_PER_FIELD - 1; j >= 0; j--) begin
        w_nib = w_stage_m[(k*DIGITS_PER_FIELD + j)*4 +: 4];
        if (w_nib != 4'd0) w_lead = 1'b0;
        if (w_ovf_m[k])                        w_byte = {1'b1, SEG_DASH};
        else if (r_blank_lz && w_lead && j != 0) w_byte = {1'b1, SEG_BLANK};
        else                                   w_byte = {1'b1, seg_encode(w_nib)};
        w_byte[SEG_DP_BIT] = ~r_dp[k*DIGITS_PER_FIELD + j];
        w_hex_next[(k*DIGITS_PER_FIELD + j)*8 +: 8] = w_byte;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_values    <= '0;
      r_dp        <= '0;
      r_blank_lz  <= 1'b0;
      r_field     <= '0;
      r_cnt       <= '0;
      r_stage     <= '0;
      r_stage_ovf <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hex         <= '1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (update) begin
            r_values   <= values;
            r_dp       <= dp_mask;
            r_blank_lz <= blank_lz;
            r_field    <= '0;
            busy       <= 1'b1;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_step) r_state <= ST_STORE;
        end
        ST_STORE: begin
          r_stage     <= w_stage_m;
          r_stage_ovf <= w_ovf_m;
          if (r_field == c_last_field) begin
            hex     <= w_hex_next;
            done    <= 1'b1;
            r_state <= ST_COMMIT;
          end else begin
            r_field <= r_field + 1'b1;
            r_state <= ST_LOAD;
          end
        end
        ST_COMMIT: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_display_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_seven_seg_display_ctrl                                            |
// | Scoreboard bench with a decimal reference model for the controller.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_seven_seg_display_ctrl;
  localparam int NF    = 3;
  localparam int FW    = 7;
  localparam int DPF   = 2;
  localparam int ND    = NF * DPF;
  localparam int HEX_W = ND * 8;
  localparam int LAT   = NF * (FW + 2) + 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             update = 1'b0;
  logic             blank_lz = 1'b0;
  logic [NF*FW-1:0] values = '0;
  logic [ND-1:0]    dp_mask = '0;
  logic             busy, done;
  logic [HEX_W-1:0] hex;

  seven_seg_display_ctrl #(
    .NUM_FIELDS(NF), .FIELD_W(FW), .DIGITS_PER_FIELD(DPF)
  ) dut (
    .clock(clock), .reset(reset), .update(update), .values(values),
    .dp_mask(dp_mask), .blank_lz(blank_lz), .busy(busy), .done(done), .hex(hex)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [HEX_W-1:0] exp_q[$];
  int               acc_q[$];
  int               last_acc = -1000;
  int               n_cmp = 0;
  int               n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [7:0] digit_code(input int d);
    case (d)
      0: return 8'hC0; 1: return 8'hF9; 2: return 8'hA4; 3: return 8'hB0;
      4: return 8'h99; 5: return 8'h92; 6: return 8'h82; 7: return 8'hF8;
      8: return 8'h80; default: return 8'h90;
    endcase
  endfunction

  // Reference: plain decimal arithmetic on each field value.
  function automatic logic [HEX_W-1:0] model(input logic [NF*FW-1:0] v,
                                              input logic [ND-1:0] dp, input logic blz);
    logic [HEX_W-1:0] h;
    logic [7:0]       s;
    int               f, p, lim;
    h = '1;
    lim = 10 ** DPF;
    for (int k = 0; k < NF; k++) begin
      f = int'(v[k*FW +: FW]);
      p = 1;
      for (int j = 0; j < DPF; j++) begin
        if (f >= lim)                   s = 8'hBF;
        else if (blz && j > 0 && f < p) s = 8'hFF;
        else                            s = digit_code((f / p) % 10);
        if (dp[k*DPF + j]) s[7] = 1'b0;
        h[(k*DPF + j)*8 +: 8] = s;
        p = p * 10;
      end
    end
    return h;
  endfunction

  function automatic logic [NF*FW-1:0] rand_vals();
    logic [NF*FW-1:0] v;
    int f;
    v = '0;
    for (int k = 0; k < NF; k++) begin
      case ($urandom_range(0, 3))
        0:       f = int'($urandom_range(0, 9));
        1:       f = int'($urandom_range(95, 105));
        default: f = int'($urandom_range(0, 127));
      endcase
      v[k*FW +: FW] = FW'(f);
    end
    return v;
  endfunction

  // Drive one update at the current negedge; the scoreboard only expects a
  // result when the request lands while the controller should be idle.
  task automatic issue(input logic [NF*FW-1:0] v, input logic [ND-1:0] dp, input logic blz);
    values = v; dp_mask = dp; blank_lz = blz; update = 1'b1;
    if (cyc >= last_acc + LAT + 1) begin
      exp_q.push_back(model(v, dp, blz));
      acc_q.push_back(cyc);
      last_acc = cyc;
    end
    @(negedge clock);
    update   = 1'b0;
    values   = (NF*FW)'($urandom);
    dp_mask  = ND'($urandom);
    blank_lz = 1'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (!done && k < budget) begin
      @(negedge clock);
      k++;
    end
    check("done_seen", {63'd0, done}, 64'd1);
  endtask

  // Monitor: every done pops the oldest expectation and its accept time.
  always @(negedge clock) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, required no pending request", cyc);
      end else begin
        check("hex_commit", hex, exp_q.pop_front());
        check("latency", 64'(cyc - acc_q.pop_front()), 64'(LAT));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  initial begin
    logic [HEX_W-1:0] hold;
    int bad, k;

    repeat (3) @(negedge clock);
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_hex", hex, {HEX_W{1'b1}});
    reset = 1'b0;
    @(negedge clock);

    // 12:34:56, plus busy/done timing window
    issue({7'd12, 7'd34, 7'd56}, '0, 1'b0);
    bad = 0;
    for (int i = 1; i <= LAT; i++) begin
      if (busy !== 1'b1) bad++;
      if (i < LAT) begin
        if (done !== 1'b0) bad++;
        @(negedge clock);
      end
    end
    check("t1_done", {63'd0, done}, 64'd1);
    check("t1_hex_literal", hex, 48'hF9A4_B099_9282);
    @(negedge clock);
    check("t1_busy_window", 64'(bad), 64'd0);
    check("t1_busy_after", {63'd0, busy}, 64'd0);
    check("t1_done_after", {63'd0, done}, 64'd0);

    // leading-zero blanking
    issue({7'd7, 7'd5, 7'd0}, '0, 1'b1);
    wait_done(LAT + 5);
    check("t2_hex_literal", hex, 48'hFFF8_FF92_FFC0);
    @(negedge clock);

    // overflow with decimal point on a dashed digit
    issue({7'd100, 7'd99, 7'd120}, 6'b000010, 1'b0);
    wait_done(LAT + 5);
    check("t3_hex_literal", hex, 48'hBFBF_9090_3FBF);
    @(negedge clock);

    // second update while busy is dropped
    issue({7'd1, 7'd2, 7'd3}, 6'b100001, 1'b0);
    repeat (4) @(negedge clock);
    issue({7'd44, 7'd55, 7'd66}, 6'b010101, 1'b1);
    wait_done(LAT + 5);
    repeat (LAT + 5) @(negedge clock);

    // back-to-back: update in the cycle right after done
    issue({7'd59, 7'd8, 7'd40}, 6'b001100, 1'b1);
    wait_done(LAT + 5);
    hold = model({7'd59, 7'd8, 7'd40}, 6'b001100, 1'b1);
    @(negedge clock);
    bad = 0;
    if (hex !== hold) bad++;
    issue({7'd3, 7'd71, 7'd9}, 6'b000000, 1'b0);
    k = 0;
    while (!done && k < LAT + 5) begin
      if (hex !== hold) bad++;
      @(negedge clock);
      k++;
    end
    check("t5_hold_between_commits", 64'(bad), 64'd0);
    check("t5_second_done", {63'd0, done}, 64'd1);
    @(negedge clock);

    // reset mid-conversion aborts without a done pulse
    issue({7'd11, 7'd22, 7'd33}, '0, 1'b0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    exp_q.delete();
    acc_q.delete();
    last_acc = -1000;
    @(negedge clock);
    check("t6_abort_busy", {63'd0, busy}, 64'd0);
    check("t6_abort_hex", hex, {HEX_W{1'b1}});
    check("t6_abort_done", {63'd0, done}, 64'd0);
    reset = 1'b0;
    repeat (LAT + 10) @(negedge clock);

    // randomized traffic, including requests that land while busy
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 34)) @(negedge clock);
      issue(rand_vals(), ND'($urandom), 1'($urandom));
    end
    k = 0;
    while (exp_q.size() != 0 && k < 3 * LAT) begin
      @(negedge clock);
      k++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    repeat (5) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seven_seg_display_ctrl.md
Name: seven_seg_display_ctrl

Overview:
Parametrised, sequential replacement for the stopwatch's combinational seven-segment encoder. It accepts NUM_FIELDS binary fields (mins/secs/hundredths by default) on a single-cycle update strobe. It converts each field to DIGITS_PER_FIELD BCD digits with an iterative shift-add-3 engine, one field at a time. It then commits all segment patterns to the HEX outputs atomically, adding per-digit decimal points, leading-zero blanking and overflow indication.

Parameters:
NUM_FIELDS, 3, number of binary input fields; field 0 is the least significant (rightmost)
FIELD_W, 7, width of each binary field in bits
DIGITS_PER_FIELD, 2, decimal digits displayed per field (1..4)

Ports:
clock  input  1  system clock; all state changes on rising edge
reset  input  1  synchronous, active-high reset
update  input  1  single-cycle request to capture values and start conversion
values  input  NUM_FIELDS*FIELD_W  packed binary fields; field k at [k*FIELD_W +: FIELD_W]
dp_mask  input  NUM_FIELDS*DIGITS_PER_FIELD  1 = light decimal point of that digit; digit j of field k at index k*DIGITS_PER_FIELD+j (j=0 units)
blank_lz  input  1  1 = blank leading zeros within each field
busy  output  1  high while a conversion is in progress
done  output  1  single-cycle pulse in the cycle hex is updated
hex  output  NUM_FIELDS*DIGITS_PER_FIELD*8  segment bytes; byte index as for dp_mask; bit7 = DP, bits6:0 = g..a; all active-low

Behaviour:
- Reset: state IDLE; busy=0, done=0, hex all 8'hFF (blank); internal shift/BCD registers cleared.
- values, dp_mask and blank_lz are captured in the accept cycle (update=1 while IDLE); later input changes do not affect the conversion in flight.
- update while busy=1 is ignored; no queuing.
- FSM: IDLE -> LOAD -> SHIFT -> STORE -> (LOAD next field | COMMIT) -> IDLE.
- LOAD (1 cycle): load the current field into the shift register and clear the BCD accumulator.
- SHIFT (FIELD_W cycles): per cycle, add 3 to every BCD nibble that is >=5, then shift left by 1, taking the field MSB into the accumulator.
- STORE (1 cycle): write the field's digits to a staging buffer. Overflow flag = field value >= 10^DIGITS_PER_FIELD, computed from the full accumulator. The accumulator is sized for ceil(FIELD_W*log10(2)) digits, min DIGITS_PER_FIELD.
- COMMIT (1 cycle): hex <= staging buffer encoded; done=1 for this cycle only; then IDLE.
- Latency: done asserts NUM_FIELDS*(FIELD_W+2)+1 cycles after the accept cycle (defaults: 28). busy is high from the cycle after accept until the done cycle inclusive.
- Back-to-back: update in the cycle after done is accepted normally.
- Encoding, active-low: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, dash=BF, blank=FF.
- DP: if the dp_mask bit is 1, bit7 is cleared; this applies to blanked and dash digits too.
- Overflow: every digit of that field shows dash. Other fields are unaffected.
- Leading-zero blanking (blank_lz=1): within a field, zero digits more significant than the highest non-zero digit show blank. The units digit (j=0) is never blanked. Blanking is not applied to an overflowed field.
- Reset mid-conversion aborts immediately: hex returns to FF and no done pulse is issued.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Shared package seven_seg_pkg: segment constants (SEG_0..SEG_9, SEG_DASH, SEG_BLANK), DP bit index, FSM state enum, and a function seg_encode(nibble) returning 7 bits.
- One sub-module, bcd_shift_add3: parametrised by FIELD_W and digit count. It provides load/step controls and presents the accumulator and overflow flag. The controller holds the FSM, staging buffer and output registers.

Test Plan:
- Reset then values {mins=12, secs=34, hund=56}, dp_mask=0, blank_lz=0, one update -> done at +28 cycles. hex bytes (field0 j0..field2 j1) = 82,92,99,B0,A4,F9; busy high 28 cycles.
- values {0,5,7}, blank_lz=1 -> field2 = FF,F8 (blank 10s, '7'); field1 = FF,92; field0 = FF,C0 (units 0 still shown).
- values field0=120, field1=99, field2=100, dp_mask bit1 set -> field0 = BF,3F (dash with DP); field1 = 90,90; field2 = BF,BF.
- Second update at +5 cycles with different values -> ignored. Output reflects the first values; exactly one done pulse.
- Update immediately after done with new values -> accepted; second done 28 cycles later; hex unchanged between the two commits.
- reset asserted at +10 cycles mid-conversion -> next cycle busy=0, hex all FF, no done pulse.
